// File: rtl/bus_mem_responder.sv
// Byte-wide RAM responder for the control unit's MR/MW strobe bus.
// Reads return on the strobe's second low cycle; protocol errors are latched.
module bus_mem_responder #(
  parameter int                ADDR_W = 16,
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 1024,
  parameter logic [DATA_W-1:0] FILL   = 8'hFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mr_n,
  input  logic              mw_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              write_done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [7:0]        rd_count,
  output logic [7:0]        wr_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_UNMAP   = 2'd1;
  localparam logic [1:0] CODE_ADDRCHG = 2'd2;
  localparam logic [1:0] CODE_BOTH    = 2'd3;

  // IDLE: await a falling strobe | RD_HOLD: read data held while mr_n low | FAULT_HOLD: wait for both strobes high
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RD_HOLD    = 2'd1,
    S_FAULT_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mr_q, mw_q;
  logic [ADDR_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              wdone_q, wdone_d;
  logic              fault_q, fault_d;
  logic [1:0]        code_q, code_d;
  logic [7:0]        rdc_q, rdc_d;
  logic [7:0]        wrc_q, wrc_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic              mapped;
  logic              rd_fall, wr_fall, both_low;
  logic              flt_set;
  logic [1:0]        flt_code;

  assign mapped    = ({1'b0, addr} < DEPTH_LIM);
  assign ram_rdata = mem[addr[AW-1:0]];
  assign rd_fall   = !mr_n && mr_q;
  assign wr_fall   = !mw_n && mw_q;
  assign both_low  = !mr_n && !mw_n;

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    dout_d   = dout_q;
    wdone_d  = 1'b0;
    fault_d  = fault_q;
    code_d   = code_q;
    rdc_d    = rdc_q;
    wrc_d    = wrc_q;
    ram_we   = 1'b0;
    flt_set  = 1'b0;
    flt_code = CODE_NONE;

    case (state_q)
      S_IDLE: begin
        if (both_low) begin
          flt_set  = 1'b1;
          flt_code = CODE_BOTH;
          state_d  = S_FAULT_HOLD;
        end else if (rd_fall && mw_n) begin
          cap_d   = addr;
          dout_d  = mapped ? ram_rdata : FILL;
          rdc_d   = rdc_q + 8'd1;
          state_d = S_RD_HOLD;
          if (!mapped) begin
            flt_set  = 1'b1;
            flt_code = CODE_UNMAP;
          end
        end else if (wr_fall && mr_n) begin
          if (mapped) begin
            ram_we  = 1'b1;
            wdone_d = 1'b1;
            wrc_d   = wrc_q + 8'd1;
          end else begin
            flt_set  = 1'b1;
            flt_code = CODE_UNMAP;
          end
        end
      end

      S_RD_HOLD: begin
        if (both_low) begin
          flt_set  = 1'b1;
          flt_code = CODE_BOTH;
          state_d  = S_FAULT_HOLD;
        end else if (mr_n) begin
          state_d = S_IDLE;
        end else if (addr != cap_q) begin
          flt_set  = 1'b1;
          flt_code = CODE_ADDRCHG;
          state_d  = S_FAULT_HOLD;
        end
      end

      S_FAULT_HOLD: begin
        if (both_low) begin
          flt_set  = 1'b1;
          flt_code = CODE_BOTH;
        end else if (mr_n && mw_n) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Only the first cause is kept; the flag itself is sticky.
    if (flt_set) begin
      fault_d = 1'b1;
      if (!fault_q) code_d = flt_code;
    end

    dvalid_d = (state_d == S_RD_HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mr_q     <= 1'b1;
      mw_q     <= 1'b1;
      cap_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= CODE_NONE;
      rdc_q    <= 8'd0;
      wrc_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      mr_q     <= mr_n;
      mw_q     <= mw_n;
      cap_q    <= cap_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      wdone_q  <= wdone_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      rdc_q    <= rdc_d;
      wrc_q    <= wrc_d;
    end
  end

  // RAM contents survive reset; a strobe coinciding with reset never commits.
  always_ff @(posedge clock) begin
    if (!reset && ram_we) mem[addr[AW-1:0]] <= data_in;
  end

  assign data_out   = dout_q;
  assign data_valid = dvalid_q;
  assign write_done = wdone_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign rd_count   = rdc_q;
  assign wr_count   = wrc_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench: stimulus pushes expected reads/write pulses, a monitor pops and compares.
module tb_bus_mem_responder;
  localparam int DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic        mr_n = 1'b1;
  logic        mw_n = 1'b1;
  logic [7:0]  data_out;
  logic        data_valid, write_done, fault;
  logic [1:0]  fault_code;
  logic [7:0]  rd_count, wr_count;

  bus_mem_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .FILL(8'hFF)) dut (
    .clock(clock), .reset(reset), .addr(addr), .data_in(data_in),
    .mr_n(mr_n), .mw_n(mw_n), .data_out(data_out), .data_valid(data_valid),
    .write_done(write_done), .fault(fault), .fault_code(fault_code),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct { logic [7:0] data; int cyc; } rd_exp_t;
  rd_exp_t rd_q[$];
  int      wd_q[$];

  // Reference model: memory image, counters and first-fault record.
  logic [7:0] model_mem [int];
  int         waddrs[$];
  logic [7:0] m_rd, m_wr;
  bit         m_fault;
  logic [1:0] m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_flt(input logic [1:0] c);
    if (!m_fault) m_code = c;
    m_fault = 1'b1;
  endtask

  task automatic model_reset();
    m_rd = 8'd0; m_wr = 8'd0; m_fault = 1'b0; m_code = 2'd0;
  endtask

  task automatic chk_status(input string name);
    chk({name, ".rd_count"},   rd_count,   m_rd);
    chk({name, ".wr_count"},   wr_count,   m_wr);
    chk({name, ".fault"},      fault,      m_fault);
    chk({name, ".fault_code"}, fault_code, m_code);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; mr_n = 1'b1; mw_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    addr = a; data_in = d; mw_n = 1'b0;
    if (a < DEPTH) begin
      if (!model_mem.exists(int'(a))) waddrs.push_back(int'(a));
      model_mem[int'(a)] = d;
      m_wr++;
      wd_q.push_back(cyc + 1);
    end else begin
      model_flt(2'd1);
    end
    @(negedge clock);
    mw_n = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] a, input int nlow, input bit no_wait);
    rd_exp_t e;
    if (!no_wait) @(negedge clock);
    addr = a; mr_n = 1'b0;
    e.data = (a < DEPTH) ? model_mem[int'(a)] : 8'hFF;
    e.cyc  = cyc + 1;
    rd_q.push_back(e);
    m_rd++;
    if (a >= DEPTH) model_flt(2'd1);
    repeat (nlow) @(negedge clock);
    mr_n = 1'b1;
  endtask

  // Monitor
  initial begin
    bit         prev_valid;
    logic [7:0] last_dout;
    rd_exp_t    e;
    int         wc;
    prev_valid = 1'b0;
    last_dout  = '0;
    forever begin
      @(posedge clock);
      #1;
      if (data_valid && !prev_valid) begin
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: data_valid rose with data %0h, expected no read (cycle %0d)", data_out, cyc);
        end else begin
          e = rd_q.pop_front();
          chk("rd_data", data_out, e.data);
          chk("rd_latency", cyc, e.cyc);
        end
        last_dout = data_out;
      end else if (data_valid && prev_valid) begin
        chk("rd_hold", data_out, last_dout);
      end
      if (write_done) begin
        if (wd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write_done: got pulse, expected none (cycle %0d)", cyc);
        end else begin
          wc = wd_q.pop_front();
          chk("wd_cycle", cyc, wc);
        end
      end
      prev_valid = data_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          op;

    model_reset();
    do_reset();
    chk("rst.data_out",   data_out,   8'h00);
    chk("rst.data_valid", data_valid, 1'b0);
    chk("rst.write_done", write_done, 1'b0);
    chk_status("rst");

    // Basic write then two-cycle read
    do_write(16'h0010, 8'hA5);
    chk_status("wr10");
    do_read(16'h0010, 2, 1'b0);
    chk("rd10.valid_held", data_valid, 1'b1);
    chk("rd10.data", data_out, 8'hA5);
    @(posedge clock); #1;
    chk("rd10.valid_drop", data_valid, 1'b0);
    chk_status("rd10");

    // PUSH/POP at the top of mapped space
    do_reset();
    do_write(16'h03FF, 8'h3C);
    do_write(16'h03FE, 8'h07);
    do_read(16'h03FF, 2, 1'b0);
    do_read(16'h03FE, 2, 1'b0);
    chk_status("pushpop");
    chk("pushpop.wr_count", wr_count, 8'd2);
    chk("pushpop.rd_count", rd_count, 8'd2);

    // Read one cycle after a write to the same address
    do_write(16'h0155, 8'h42);
    do_read(16'h0155, 1, 1'b1);
    chk_status("fwd");

    // Unmapped read then unmapped write
    do_reset();
    do_read(16'h0400, 2, 1'b0);
    chk("unmap.data", data_out, 8'hFF);
    chk_status("unmap_rd");
    do_write(16'h0400, 8'h11);
    chk_status("unmap_wr");
    chk("unmap.code", fault_code, 2'd1);

    // Both strobes low, then an address change during a held read
    do_reset();
    @(negedge clock);
    addr = 16'h0030; data_in = 8'hEE; mr_n = 1'b0; mw_n = 1'b0;
    model_flt(2'd3);
    @(negedge clock);
    mr_n = 1'b1; mw_n = 1'b1;
    chk_status("both");
    chk("both.code", fault_code, 2'd3);
    do_write(16'h0030, 8'h5A);
    begin
      rd_exp_t e;
      @(negedge clock);
      addr = 16'h0030; mr_n = 1'b0;
      e.data = 8'h5A; e.cyc = cyc + 1;
      rd_q.push_back(e);
      m_rd++;
      @(negedge clock);
      addr = 16'h0031;
      model_flt(2'd2);
      @(negedge clock);
      mr_n = 1'b1;
    end
    chk_status("addrchg");
    chk("addrchg.code", fault_code, 2'd3);

    // Write strobe falling on the reset edge must not commit
    do_reset();
    do_write(16'h0020, 8'h99);
    @(negedge clock);
    reset = 1'b1; addr = 16'h0020; data_in = 8'h55; mw_n = 1'b0;
    @(negedge clock);
    reset = 1'b0; mw_n = 1'b1;
    model_reset();
    do_read(16'h0020, 2, 1'b0);
    chk("rstwr.data", data_out, 8'h99);
    chk_status("rstwr");

    // Read counter wrap
    do_reset();
    for (int i = 0; i < 260; i++) do_read(16'h0020, 1, 1'b0);
    chk_status("wrap");
    chk("wrap.rd_count", rd_count, 8'd4);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        a = ($urandom_range(0, 15) == 0) ? 16'(DEPTH + $urandom_range(0, 1000))
                                         : 16'($urandom_range(0, DEPTH - 1));
        d = 8'($urandom);
        do_write(a, d);
      end else if (op <= 6) begin
        a = ($urandom_range(0, 15) == 0) ? 16'(DEPTH + $urandom_range(0, 1000))
                                         : 16'(waddrs[$urandom_range(0, waddrs.size() - 1)]);
        do_read(a, $urandom_range(1, 3), 1'b0);
      end else if (op == 7) begin
        a = 16'($urandom_range(0, DEPTH - 1));
        d = 8'($urandom);
        do_write(a, d);
        do_read(a, $urandom_range(1, 2), 1'b1);
      end else begin
        a = 16'(waddrs[$urandom_range(0, waddrs.size() - 1)]);
        do_read(a, 1, 1'b0);
        a = 16'(waddrs[$urandom_range(0, waddrs.size() - 1)]);
        do_read(a, $urandom_range(1, 3), 1'b0);
      end
      chk_status("rand");
    end

    repeat (4) @(negedge clock);
    chk("end.rd_q_empty", rd_q.size(), 0);
    chk("end.wd_q_empty", wd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the microcoded control unit's external bus.
- Services the controller's active-low read/write strobes (MR/MW, asserted in PC, MA and SP address phases) against an internal byte-wide RAM.
- Returns read data timed to the controller's LMD/LAC/LMAH/LMAL latch cycle.
- Flags protocol violations so microcode sequences (fetch, PUSH/POP, DIV loops) can be checked in simulation.

Parameters:
- ADDR_W, 16, address bus width (MAH:MAL or SP).
- DATA_W, 8, data bus width.
- DEPTH, 1024, implemented RAM words; addresses >= DEPTH are unmapped.
- FILL, 8'hFF, value returned for unmapped reads.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  address from the controller's selected source; stable from the cycle before the strobe until the strobe rises.
- data_in  in  DATA_W  write data from the controller (flags or DES bus).
- mr_n  in  1  read strobe, active low.
- mw_n  in  1  write strobe, active low.
- data_out  out  DATA_W  read data to the MD/AC bus.
- data_valid  out  1  data_out holds the result of the current read.
- write_done  out  1  one-cycle pulse, write committed.
- fault  out  1  sticky protocol/address error.
- fault_code  out  2  first fault cause: 0 none, 1 unmapped address, 2 address changed during strobe, 3 mr_n and mw_n low together.
- rd_count  out  8  completed reads, wraps at 255->0.
- wr_count  out  8  committed writes, wraps.

Behaviour:
- Reset has priority over all other behaviour.
  - On a clock edge with reset=1: data_out=0, data_valid=0, write_done=0, fault=0, fault_code=0, rd_count=0, wr_count=0, FSM=IDLE, and the strobe history register is forced high.
  - RAM contents are not cleared.
  - A strobe sampled on the same edge as reset is discarded; no write commits.
- The block registers the previous values of mr_n and mw_n. A falling strobe is a sample of 0 with a previous sample of 1.
- FSM states: IDLE, RD_HOLD, FAULT_HOLD.
- IDLE, mr_n falling and mw_n=1:
  - Capture addr and read RAM[addr], or FILL if unmapped, into data_out.
  - data_valid=1 from the next cycle, which is the controller's second MR-low cycle (latch cycle). Latency is 1 clock.
  - rd_count+1. Next state RD_HOLD.
- IDLE, mw_n falling and mr_n=1:
  - Write data_in to RAM[addr] on that edge; single-cycle strobe suffices.
  - write_done=1 for the following cycle only. wr_count+1. Stay IDLE.
  - mw_n held low further does not re-write.
- RD_HOLD:
  - data_out and data_valid are held while mr_n=0.
  - If addr differs from the captured address while mr_n=0: set fault code 2 and go to FAULT_HOLD. data_out is unchanged.
  - mr_n=1: go to IDLE. data_valid drops the cycle after, and data_out keeps its last value.
- Both strobes low on any sample:
  - No RAM write and no read.
  - Fault code 3; go to FAULT_HOLD.
- Unmapped address (addr >= DEPTH) on a falling strobe:
  - A read returns FILL, counts, and proceeds normally.
  - A write is dropped, with no write_done and no wr_count increment.
  - Both set fault code 1.
- FAULT_HOLD: wait until mr_n=1 and mw_n=1, then go to IDLE.
- Fault recording:
  - fault is sticky until reset.
  - fault_code records only the first fault; later faults do not overwrite it.
- Ordering:
  - A read one cycle after a write to the same address returns the new data (write-then-read forwarding through the RAM).
  - A new falling mr_n on the cycle after mr_n rises is legal and starts a new read.
- Counters wrap modulo 256 silently.

Test Plan:
- Reset, then write 8'hA5 to 16'h0010 (mw_n low 1 cycle) -> write_done pulses 1 cycle after the edge; wr_count=1; fault=0.
- Read 16'h0010 with mr_n low 2 cycles -> data_out=8'hA5 and data_valid=1 in the second low cycle; rd_count=1; data_valid=0 one cycle after mr_n rises.
- PUSH/POP sequence:
  - Stimulus: write 8'h3C to 16'h03FF, write 8'h07 to 16'h03FE, read 16'h03FF, read 16'h03FE.
  - Required response: reads return 8'h3C then 8'h07; wr_count=2; rd_count=2.
- Read 16'h0400 -> data_out=8'hFF; fault=1; fault_code=1. Then write 16'h0400 -> no write_done; wr_count unchanged; fault_code stays 1.
- After reset, drive mr_n=0 and mw_n=0 together -> no commit; fault_code=3. A following change of addr during a held read does not change fault_code.
- Write 8'h55 with mw_n falling on the same edge as reset=1 -> a later read of that address returns the prior contents; wr_count=0.
